// File: rtl/c7bbiu_rd_rr.sv
// c7bbiu_rd_rr: round-robin arbiter of NREQ read requesters onto one AXI read master,
// with per-requester outstanding tracking. Define C7BBIU_RD_CANCEL_EN for cancel/drop support.
module c7bbiu_rd_rr #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32,
   parameter int unsigned OUTS = 2,
   parameter int unsigned IDW  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_rd_req,
   input  logic [NREQ*AW-1:0] req_rd_addr,
   input  logic [NREQ-1:0]    req_rd_cancel,
   output logic [NREQ-1:0]    biu_req_rd_ack,
   output logic [NREQ-1:0]    biu_req_data_valid,
   output logic [DW-1:0]      biu_req_data,
   output logic [1:0]         biu_req_resp,
   input  logic               ext_biu_ar_ready,
   output logic               biu_ext_ar_valid,
   output logic [IDW-1:0]     biu_ext_ar_id,
   output logic [AW-1:0]      biu_ext_ar_addr,
   output logic [7:0]         biu_ext_ar_len,
   output logic [2:0]         biu_ext_ar_size,
   output logic [1:0]         biu_ext_ar_burst,
   output logic               biu_ext_ar_lock,
   output logic [3:0]         biu_ext_ar_cache,
   output logic [2:0]         biu_ext_ar_prot,
   output logic               biu_ext_r_ready,
   input  logic               ext_biu_r_valid,
   input  logic [IDW-1:0]     ext_biu_r_id,
   input  logic [DW-1:0]      ext_biu_r_data,
   input  logic               ext_biu_r_last,
   input  logic [1:0]         ext_biu_r_resp
);

   localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [2:0]  ArSize = 3'($clog2(DW / 8));

   logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [2:0]     out_cnt_q [NREQ];
   logic [2:0]     out_cnt_d [NREQ];
   logic           ar_valid_q;
   logic [IDW-1:0] ar_id_q;
   logic [AW-1:0]  ar_addr_q;

   logic [NREQ-1:0] eligible, r_hit, r_done, deliver;
   logic            slot_free, grant_vld;
   logic [PW-1:0]   grant_idx;
   logic [31:0]     scan_idx;

   assign slot_free = !ar_valid_q || ext_biu_ar_ready;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         eligible[i] = req_rd_req[i] && (out_cnt_q[i] < 3'(OUTS));
      end
   end

   // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = (32'(rr_ptr_q) + k) % NREQ;
         if (!grant_vld && slot_free && !reset && eligible[scan_idx[PW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_vld) begin
         rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

   // Beats for unmapped IDs or idle requesters match nothing and are silently dropped.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         biu_req_rd_ack[i] = grant_vld && (grant_idx == PW'(i));
         r_hit[i]  = !reset && ext_biu_r_valid && (32'(ext_biu_r_id) == i) &&
                     (out_cnt_q[i] != 3'd0);
         r_done[i] = r_hit[i] && ext_biu_r_last;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         out_cnt_d[i] = out_cnt_q[i];
         if (biu_req_rd_ack[i] && !r_done[i]) begin
            out_cnt_d[i] = out_cnt_q[i] + 3'd1;
         end else if (!biu_req_rd_ack[i] && r_done[i]) begin
            out_cnt_d[i] = out_cnt_q[i] - 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q   <= '0;
         ar_valid_q <= 1'b0;
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         for (int i = 0; i < NREQ; i++) begin
            out_cnt_q[i] <= '0;
         end
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         out_cnt_q <= out_cnt_d;
         if (grant_vld) begin
            ar_valid_q <= 1'b1;
            ar_id_q    <= IDW'(grant_idx);
            ar_addr_q  <= req_rd_addr[grant_idx*AW +: AW];
         end else if (ext_biu_ar_ready) begin
            ar_valid_q <= 1'b0;
         end
      end
   end

`ifdef C7BBIU_RD_CANCEL_EN
   logic [2:0] drop_cnt_q [NREQ];
   logic [2:0] drop_cnt_d [NREQ];

   // A cancel snapshots the post-update outstanding count; those returns are swallowed.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         deliver[i]    = r_hit[i] && (drop_cnt_q[i] == 3'd0);
         drop_cnt_d[i] = drop_cnt_q[i];
         if (r_done[i] && (drop_cnt_q[i] != 3'd0)) begin
            drop_cnt_d[i] = drop_cnt_q[i] - 3'd1;
         end
         if (req_rd_cancel[i]) begin
            drop_cnt_d[i] = out_cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREQ; i++) begin
            drop_cnt_q[i] <= '0;
         end
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end
`else
   logic unused_cancel;
   assign unused_cancel = ^req_rd_cancel;
   assign deliver       = r_hit;
`endif

   assign biu_req_data_valid = deliver;
   assign biu_req_data       = reset ? '0 : ext_biu_r_data;
   assign biu_req_resp       = reset ? 2'b00 : ext_biu_r_resp;
   assign biu_ext_r_ready    = !reset;

   assign biu_ext_ar_valid = ar_valid_q && !reset;
   assign biu_ext_ar_id    = reset ? '0 : ar_id_q;
   assign biu_ext_ar_addr  = reset ? '0 : ar_addr_q;
   assign biu_ext_ar_len   = 8'd0;
   assign biu_ext_ar_size  = reset ? 3'd0 : ArSize;
   assign biu_ext_ar_burst = reset ? 2'b00 : 2'b01;
   assign biu_ext_ar_lock  = 1'b0;
   assign biu_ext_ar_cache = 4'b0000;
   assign biu_ext_ar_prot  = 3'b000;

endmodule

// File: tb/tb_c7bbiu_rd_rr.sv
// Bench for c7bbiu_rd_rr: directed scenarios then random traffic, all checked each cycle
// against a transaction-level model (outstanding/drop counts, last-granted pointer, AR slot).
module tb_c7bbiu_rd_rr;
   localparam int NREQ = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int OUTS = 2;
   localparam int IDW  = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_rd_req, req_rd_cancel, biu_req_rd_ack, biu_req_data_valid;
   logic [NREQ*AW-1:0] req_rd_addr;
   logic [DW-1:0]      biu_req_data, ext_biu_r_data;
   logic [1:0]         biu_req_resp, biu_ext_ar_burst, ext_biu_r_resp;
   logic               ext_biu_ar_ready, biu_ext_ar_valid, biu_ext_ar_lock, biu_ext_r_ready;
   logic               ext_biu_r_valid, ext_biu_r_last;
   logic [IDW-1:0]     biu_ext_ar_id, ext_biu_r_id;
   logic [AW-1:0]      biu_ext_ar_addr;
   logic [7:0]         biu_ext_ar_len;
   logic [2:0]         biu_ext_ar_size, biu_ext_ar_prot;
   logic [3:0]         biu_ext_ar_cache;

   always #5 clk = ~clk;

   c7bbiu_rd_rr #(.NREQ(NREQ), .AW(AW), .DW(DW), .OUTS(OUTS), .IDW(IDW)) dut (
      .clk                (clk),
      .reset              (reset),
      .req_rd_req         (req_rd_req),
      .req_rd_addr        (req_rd_addr),
      .req_rd_cancel      (req_rd_cancel),
      .biu_req_rd_ack     (biu_req_rd_ack),
      .biu_req_data_valid (biu_req_data_valid),
      .biu_req_data       (biu_req_data),
      .biu_req_resp       (biu_req_resp),
      .ext_biu_ar_ready   (ext_biu_ar_ready),
      .biu_ext_ar_valid   (biu_ext_ar_valid),
      .biu_ext_ar_id      (biu_ext_ar_id),
      .biu_ext_ar_addr    (biu_ext_ar_addr),
      .biu_ext_ar_len     (biu_ext_ar_len),
      .biu_ext_ar_size    (biu_ext_ar_size),
      .biu_ext_ar_burst   (biu_ext_ar_burst),
      .biu_ext_ar_lock    (biu_ext_ar_lock),
      .biu_ext_ar_cache   (biu_ext_ar_cache),
      .biu_ext_ar_prot    (biu_ext_ar_prot),
      .biu_ext_r_ready    (biu_ext_r_ready),
      .ext_biu_r_valid    (ext_biu_r_valid),
      .ext_biu_r_id       (ext_biu_r_id),
      .ext_biu_r_data     (ext_biu_r_data),
      .ext_biu_r_last     (ext_biu_r_last),
      .ext_biu_r_resp     (ext_biu_r_resp)
   );

   int n_cmp = 0;
   int n_err = 0;

   int          m_outs [NREQ];
   int          m_drop [NREQ];
   int          m_rr;
   bit          m_arv;
   int          m_arid;
   logic [AW-1:0] m_araddr;
   int          pend_q [$];   // IDs of ARs the fabric has accepted but not yet answered

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NREQ; i++) begin
         m_outs[i] = 0;
         m_drop[i] = 0;
      end
      m_rr = 0; m_arv = 0; m_arid = 0; m_araddr = '0;
   endtask

   // Inputs already applied; compare outputs to the model, then advance one clock.
   task automatic cycle();
      logic [NREQ-1:0] e_ack, e_dv;
      int g, rid, idx;
      bit acc;
      #1;
      e_ack = '0; e_dv = '0; g = -1; acc = 0;
      rid = int'(ext_biu_r_id);
      if (!reset) begin
         if (!m_arv || ext_biu_ar_ready) begin
            for (int k = 0; k < NREQ; k++) begin
               idx = (m_rr + k) % NREQ;
               if (g < 0 && req_rd_req[idx] && m_outs[idx] < OUTS) g = idx;
            end
         end
         if (g >= 0) e_ack = {{(NREQ-1){1'b0}}, 1'b1} << g;
         if (ext_biu_r_valid && rid < NREQ) acc = (m_outs[rid] > 0);
         if (acc && m_drop[rid] == 0) e_dv = {{(NREQ-1){1'b0}}, 1'b1} << rid;
      end
      check("ack", 64'(biu_req_rd_ack), 64'(e_ack));
      check("data_valid", 64'(biu_req_data_valid), 64'(e_dv));
      check("r_ready", 64'(biu_ext_r_ready), 64'(!reset));
      check("ar_valid", 64'(biu_ext_ar_valid), 64'(m_arv && !reset));
      check("ar_id", 64'(biu_ext_ar_id), 64'(reset ? 0 : m_arid));
      check("ar_addr", 64'(biu_ext_ar_addr), 64'(reset ? '0 : m_araddr));
      check("ar_size", 64'(biu_ext_ar_size), 64'(reset ? 0 : 2));
      check("ar_burst", 64'(biu_ext_ar_burst), 64'(reset ? 0 : 1));
      check("ar_fixed", 64'({biu_ext_ar_len, biu_ext_ar_lock, biu_ext_ar_cache, biu_ext_ar_prot}),
            64'(0));
      check("r_data", 64'({biu_req_resp, biu_req_data}),
            64'(reset ? '0 : {ext_biu_r_resp, ext_biu_r_data}));
      @(posedge clk);
      if (reset) begin
         model_clear();
      end else begin
         if (m_arv && ext_biu_ar_ready) pend_q.push_back(m_arid);
         if (acc && ext_biu_r_last) begin
            m_outs[rid]--;
            if (m_drop[rid] > 0) m_drop[rid]--;
         end
         if (g >= 0) begin
            m_outs[g]++;
            m_rr = (g + 1) % NREQ;
            m_arv = 1; m_arid = g; m_araddr = req_rd_addr[g*AW +: AW];
         end else if (ext_biu_ar_ready) begin
            m_arv = 0;
         end
`ifdef C7BBIU_RD_CANCEL_EN
         for (int i = 0; i < NREQ; i++) begin
            if (req_rd_cancel[i]) m_drop[i] = m_outs[i];
         end
`endif
      end
      @(negedge clk);
   endtask

   // Fabric R side: answer the oldest accepted AR when enabled.
   task automatic drive_ret(input bit en);
      ext_biu_r_valid = 1'b0;
      ext_biu_r_last  = 1'b1;
      ext_biu_r_id    = '0;
      ext_biu_r_data  = $urandom;
      ext_biu_r_resp  = 2'($urandom);
      if (en && pend_q.size() > 0) begin
         ext_biu_r_valid = 1'b1;
         ext_biu_r_id    = IDW'(pend_q.pop_front());
      end
   endtask

   initial begin
      logic [NREQ-1:0] prev;
      int acks;
      model_clear();
      reset = 1'b1; req_rd_req = '0; req_rd_addr = '0; req_rd_cancel = '0;
      ext_biu_ar_ready = 1'b0;
      drive_ret(0);
      @(negedge clk);
      repeat (3) cycle();
      reset = 1'b0;
      cycle();

      // Single read with minimum latency.
      ext_biu_ar_ready = 1'b1;
      req_rd_addr[0 +: AW] = 32'h1000;
      req_rd_req = 3'b001;
      #1 check("single_ack", 64'(biu_req_rd_ack), 64'(3'b001));
      cycle();
      req_rd_req = '0;
      #1 check("single_ar", 64'({biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr}),
               64'({1'b1, 4'd0, 32'h1000}));
      cycle();
      drive_ret(1);
      ext_biu_r_data = 32'hDEAD_BEEF;
      #1 check("single_dv", 64'({biu_req_data_valid, biu_req_data}), 64'({3'b001, 32'hDEAD_BEEF}));
      cycle();

      // Round-robin between requesters 0 and 1.
      req_rd_req = 3'b011;
      prev = 3'b001;
      for (int c = 0; c < 8; c++) begin
         drive_ret(1);
         #1 check("rr_alternate", 64'((biu_req_rd_ack != prev) && (biu_req_rd_ack != '0)), 64'(1));
         prev = biu_req_rd_ack;
         cycle();
      end
      req_rd_req = '0;
      repeat (4) begin drive_ret(1); cycle(); end

      // Outstanding limit for requester 1.
      req_rd_req = 3'b010;
      acks = 0;
      repeat (4) begin
         drive_ret(0);
         #1 acks += int'(biu_req_rd_ack[1]);
         cycle();
      end
      check("outs_limit", 64'(acks), 64'(OUTS));
      drive_ret(1);
      #1 check("outs_hold", 64'(biu_req_rd_ack[1]), 64'(0));
      cycle();
      drive_ret(0);
      #1 check("outs_resume", 64'(biu_req_rd_ack[1]), 64'(1));
      cycle();
      req_rd_req = '0;
      repeat (4) begin drive_ret(1); cycle(); end

      // AR backpressure: fields frozen, no grants, release grants immediately.
      req_rd_req = 3'b101;
      ext_biu_ar_ready = 1'b0;
      req_rd_addr = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
      drive_ret(0);
      cycle();
      repeat (5) begin
         req_rd_addr = {$urandom, $urandom, $urandom};
         #1 check("bp_hold", 64'({biu_req_rd_ack, biu_ext_ar_valid, biu_ext_ar_id, biu_ext_ar_addr}),
                  64'({3'b000, 1'b1, 4'd2, 32'h3333_0000}));
         cycle();
      end
      ext_biu_ar_ready = 1'b1;
      #1 check("bp_release", 64'(biu_req_rd_ack), 64'(3'b001));
      cycle();
      req_rd_req = '0;
      repeat (5) begin drive_ret(1); cycle(); end

`ifdef C7BBIU_RD_CANCEL_EN
      // Cancel with two reads in flight swallows both returns.
      req_rd_req = 3'b001;
      cycle(); cycle();
      req_rd_req = '0; req_rd_cancel = 3'b001;
      cycle();
      req_rd_cancel = '0;
      repeat (2) begin
         drive_ret(1);
         #1 check("cancel_drop", 64'({ext_biu_r_valid, biu_req_data_valid}), 64'({1'b1, 3'b000}));
         cycle();
      end
      req_rd_req = 3'b001;
      drive_ret(0);
      cycle();
      req_rd_req = '0;
      cycle();
      drive_ret(1);
      ext_biu_r_data = 32'h55;
      #1 check("cancel_after", 64'({biu_req_data_valid, biu_req_data}), 64'({3'b001, 32'h55}));
      cycle();
`endif

      // Reset with reads in flight; a later beat for id 0 is dropped.
      req_rd_req = 3'b011;
      drive_ret(0);
      cycle(); cycle();
      req_rd_req = '0;
      reset = 1'b1;
      #1 check("reset_outputs", 64'({biu_req_rd_ack, biu_req_data_valid, biu_ext_ar_valid,
                                     biu_ext_r_ready, biu_ext_ar_addr}), 64'(0));
      cycle(); cycle();
      reset = 1'b0;
      ext_biu_r_valid = 1'b1; ext_biu_r_id = '0; ext_biu_r_last = 1'b1;
      #1 check("post_reset_drop", 64'(biu_req_data_valid), 64'(0));
      cycle();

      // Random traffic, including junk/unmapped beats, cancels and occasional reset.
      repeat (3000) begin
         reset = ($urandom_range(0, 499) == 0);
         req_rd_req = NREQ'($urandom);
         req_rd_addr = {$urandom, $urandom, $urandom};
         req_rd_cancel = ($urandom_range(0, 15) == 0) ? NREQ'($urandom) : '0;
         ext_biu_ar_ready = ($urandom_range(0, 3) != 0);
         drive_ret(($urandom_range(0, 1) == 1) && !reset);
         if (!ext_biu_r_valid && $urandom_range(0, 9) == 0) begin
            ext_biu_r_valid = 1'b1;
            ext_biu_r_id    = IDW'($urandom);
            ext_biu_r_last  = 1'($urandom);
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/c7bbiu_rd_rr.md
# c7bbiu_rd_rr

Parametrised read-side bus interface unit for the c7b core, the successor to the fixed two-requester IFU/LSU read path. It arbitrates NREQ read requesters round-robin onto a single AXI read master and tracks up to OUTS outstanding reads per requester. Read responses are routed back by AXI ID, and per-requester cancel discards stale returns. It sits between the core's fetch, load and prefetch units and the external AXI fabric, alongside the existing write arbiter.

## Interface
Parameters:
- NREQ, 2: number of requesters, 1..16; requester i uses AXI ID i.
- AW, 32: address width.
- DW, 32: data width, 32 or 64.
- OUTS, 2: maximum outstanding reads per requester, 1..7.
- IDW, 4: AXI ID width; must satisfy 2^IDW >= NREQ.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- req_rd_req  in  NREQ  per-requester read request, level.
- req_rd_addr  in  NREQ*AW  request addresses; requester i uses bits [i*AW +: AW].
- req_rd_cancel  in  NREQ  per-requester cancel pulse.
- biu_req_rd_ack  out  NREQ  one-hot grant pulse.
- biu_req_data_valid  out  NREQ  one-hot return-data strobe.
- biu_req_data  out  DW  return data, shared by all requesters.
- biu_req_resp  out  2  AXI response accompanying the data.
- ext_biu_ar_ready  in  1  AXI AR ready.
- biu_ext_ar_valid  out  1  AXI AR valid.
- biu_ext_ar_id  out  IDW  AXI AR ID.
- biu_ext_ar_addr  out  AW  AXI AR address.
- biu_ext_ar_len  out  8  AXI AR burst length.
- biu_ext_ar_size  out  3  AXI AR size.
- biu_ext_ar_burst  out  2  AXI AR burst type.
- biu_ext_ar_lock  out  1  AXI AR lock.
- biu_ext_ar_cache  out  4  AXI AR cache.
- biu_ext_ar_prot  out  3  AXI AR prot.
- biu_ext_r_ready  out  1  AXI R ready.
- ext_biu_r_valid  in  1  AXI R valid.
- ext_biu_r_id  in  IDW  AXI R ID.
- ext_biu_r_data  in  DW  AXI R data.
- ext_biu_r_last  in  1  AXI R last.
- ext_biu_r_resp  in  2  AXI R response.

## Operation
- **Eligibility:** requester i is eligible when req_rd_req[i] is high and its outstanding count out_cnt[i] < OUTS.
- **AR slot:** the slot is free when biu_ext_ar_valid is low, or when ext_biu_ar_ready is high in the same cycle (back-to-back issue, no bubble).
- **Grant:** when the slot is free, grant the first eligible requester at or after rr_ptr, searching upward mod NREQ.
  - The grant raises biu_req_rd_ack[i] combinationally.
  - It loads the AR register with that requester's address and ID i.
  - It sets rr_ptr to (i+1) mod NREQ.
  - With no eligible requester, rr_ptr is unchanged.
- **AR stability:** AR fields are held stable while valid is high and ready is low.
- **AR constants:** len=0, size=log2(DW/8), burst=2'b01 (INCR), lock=0, cache=4'b0000, prot=3'b000.
- **Outstanding counters (out_cnt[i], 3 bits):**
  - +1 on grant.
  - −1 on an accepted R beat with r_last and r_id==i.
  - Grant and return in the same cycle leave it unchanged.
  - It never exceeds OUTS.
- **R channel:**
  - biu_ext_r_ready = ~reset.
  - On r_valid: biu_req_data_valid[r_id] = 1 unless the beat is dropped.
  - biu_req_data and biu_req_resp pass through combinationally.
- **Unmapped IDs:** an r_id >= NREQ is accepted, dropped, and changes no counter.
- **Reset:** mid-operation, reset clears all counters, rr_ptr and AR valid; in-flight AXI returns arriving after reset are dropped as unmapped/underflow (out_cnt==0 means drop).

## Timing
- **Reset values:** all outputs 0, including biu_ext_r_ready during reset. After reset, AR constants show their fixed values and AR ID/address show 0.
- **Grant timing:** request in cycle T → ack in T (same cycle) → biu_ext_ar_valid in T+1.
- **Minimum latency:** with ar_ready at T+1 and r_valid at T+2, biu_req_data_valid is high in T+2 (zero added return latency).
- **Sustained throughput:** one AR per cycle when ar_ready stays high.
- **Fairness:** round-robin guarantees each eligible requester a grant within NREQ grants.

## Configuration
- **C7BBIU_RD_CANCEL_EN defined:** per-requester drop counter drop_cnt[i].
  - A req_rd_cancel[i] pulse loads drop_cnt[i] with the post-update out_cnt[i]. This covers reads acked up to and including the cancel cycle, minus any return completing that cycle.
  - Each return for i while drop_cnt[i] > 0 is accepted, suppresses data_valid, and decrements drop_cnt[i].
  - A cancel while drop_cnt > 0 reloads drop_cnt.
  - A cancel with out_cnt = 0 has no effect.
- **Undefined:** req_rd_cancel is ignored, no drop logic is present, and every mapped return is delivered.

## Test plan
- **Single read:** NREQ=2; req0 addr 0x1000, ar_ready=1, R data 0xDEADBEEF id 0 one cycle later → ack0 in T, ar_valid in T+1 with addr 0x1000 and id 0, data_valid[0] in T+2 with 0xDEADBEEF.
- **Round-robin:** req0 and req1 held high, ar_ready=1 → acks alternate 0,1,0,1; rr_ptr wraps from 1 to 0.
- **OUTS limit:** OUTS=2, req1 high, no R returns → exactly 2 acks to requester 1, then ack1 stays low until one R beat for id 1 returns, then ack1 fires the next eligible cycle.
- **AR backpressure:** ar_ready low for 5 cycles → AR addr/id stable, no further acks; ar_ready high → next grant in the same cycle.
- **Cancel (macro on):** 2 reads outstanding for requester 0, cancel pulse → next 2 returns for id 0 produce no data_valid; the following read returns 0x55 with data_valid[0]=1.
- **Reset mid-flight:** reset asserted with 2 outstanding → all outputs 0; a post-reset R beat for id 0 produces no data_valid and out_cnt stays 0.
